// File: rtl/adder_arbiter.sv
// Round-robin front end that shares one registered adder
// between NUM_REQ requesters using valid/ready handshakes.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH:0]             rsp_c,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic [WIDTH:0]             add_c,
  output logic                       busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [IW-1:0] grant;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win;
  logic          win_ok;
  logic [IW:0]   cand;
  logic          accept;
  logic          done;

  // pick the first valid requester after last_grant, wrapping
  always_comb begin
    win    = last_grant;
    win_ok = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= NREQ)
        cand = cand - NREQ;
      if (!win_ok && req_valid[cand[IW-1:0]]) begin
        win    = cand[IW-1:0];
        win_ok = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // next state, accept strobe and busy flag
  always_comb begin
    state_next = state;
    req_ready  = '0;
    busy       = 1'b1;
    accept     = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (win_ok && rst_n) begin
          req_ready  = ONE << win;
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP: begin
        if (rsp_ready[grant]) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // operand latch, result capture and response bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a      <= '0;
      add_b      <= '0;
      rsp_c      <= '0;
      rsp_valid  <= '0;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        add_a <= req_a[win*WIDTH +: WIDTH];
        add_b <= req_b[win*WIDTH +: WIDTH];
        grant <= win;
      end
      if (state == CAPTURE) begin
        rsp_c     <= add_c;
        rsp_valid <= ONE << grant;
      end
      if (done) begin
        rsp_valid  <= '0;
        last_grant <= grant;
      end
    end
  end

endmodule
